uart_cmd_ctrl: RTL and testbench

Sequencing controller for the UART receive path of the beeper music player. It gates the receiver enable and consumes one-cycle byte-done strobes with their data bytes. It assembles 4-byte note frames (header, note, length, checksum) and hands each validated note command to the tone player over a valid/ready handshake. Frames that time out or fail the checksum are dropped and flagged.

---
 rtl/beeper_pkg.sv | 28 ++
 rtl/uart_cmd_timer.sv | 31 +++
 rtl/uart_cmd_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/beeper_pkg.sv
// Shared definitions for the beeper music player.
// Holds the command FSM state encodings, the default frame header, the
// error codes reported by the UART command controller, the note-index
// width shared with the tone player and the frame checksum helper.
package beeper_pkg;

  localparam int NOTE_W = 8;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NOTE = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHKSUM  = 2'b10;

  // Mod-256 sum of header, note and length; the sender's fourth byte.
  function automatic logic [7:0] frame_sum(input logic [7:0] hdr,
                                           input logic [7:0] note,
                                           input logic [7:0] len);
    return 8'(hdr + note + len);
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter for the UART command controller.
// Ports:
//   clk, rst    : clock, async active-low reset
//   clr         : zero the counter (wins over run)
//   run         : count one cycle
//   expire      : combinational, high while running at TIMEOUT_CYC-1
module uart_cmd_timer #(
  parameter int TIMEOUT_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  // One spare count so the increment past the last value never aliases.
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
  end

  assign expire = run && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART receive-path sequencing controller for the beeper music player.
// Assembles header/note/length[/checksum] frames from receiver byte
// strobes and offers each valid note to the tone player via valid/ready.
// Bad or stalled frames are dropped with a one-cycle err strobe.
// Build option: define UART_CMD_CHECKSUM_EN for 4-byte frames with a
// checksum byte; otherwise frames are 3 bytes and no checksum error exists.
// Ports:
//   clk, rst             : clock, async active-low reset
//   enable               : run; low aborts a frame in progress
//   rx_stop, rx_data     : byte-done strobe and its byte
//   rx_en                : receiver enable (paused while a command pends)
//   cmd_valid/cmd_ready  : command handshake
//   cmd_note, cmd_len    : command payload, stable while cmd_valid
//   err, err_code        : error strobe, code held until the next err
//   busy                 : FSM not idle
module uart_cmd_ctrl
  import beeper_pkg::*;
#(
  parameter logic [7:0] HDR         = HDR_DEFAULT,
  parameter int         TIMEOUT_CYC = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rx_stop,
  input  logic [7:0]        rx_data,
  output logic              rx_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [NOTE_W-1:0] cmd_note,
  output logic [7:0]        cmd_len,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);

  logic [2:0] state, nxt;
  logic       ld_note, ld_len, err_set;
  logic [1:0] err_nxt;
  logic       t_run, t_clr, t_expire;

  // Counter runs only while a frame is partially received.
  assign t_run = (state == S_NOTE) || (state == S_LEN) || (state == S_CHK);
  assign t_clr = rx_stop || !t_run;

  uart_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (t_clr),
    .run    (t_run),
    .expire (t_expire)
  );

  // Within a frame: enable-low abort first, then a byte, then timeout,
  // so a byte arriving on the expiry cycle is still accepted.
  always_comb begin
    nxt     = state;
    ld_note = 1'b0;
    ld_len  = 1'b0;
    err_set = 1'b0;
    err_nxt = ERR_TIMEOUT;
    case (state)
      S_IDLE: if (enable && rx_stop && rx_data == HDR) nxt = S_NOTE;
      S_NOTE: begin
        if (!enable) nxt = S_IDLE;
        else if (rx_stop) begin
          ld_note = 1'b1;
          nxt     = S_LEN;
        end else if (t_expire) begin
          err_set = 1'b1;
          nxt     = S_IDLE;
        end
      end
      S_LEN: begin
        if (!enable) nxt = S_IDLE;
        else if (rx_stop) begin
          ld_len = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
          nxt    = S_CHK;
`else
          nxt    = S_HOLD;
`endif
        end else if (t_expire) begin
          err_set = 1'b1;
          nxt     = S_IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CHK: begin
        if (!enable) nxt = S_IDLE;
        else if (rx_stop) begin
          if (rx_data == frame_sum(HDR, cmd_note, cmd_len)) nxt = S_HOLD;
          else begin
            err_set = 1'b1;
            err_nxt = ERR_CHKSUM;
            nxt     = S_IDLE;
          end
        end else if (t_expire) begin
          err_set = 1'b1;
          nxt     = S_IDLE;
        end
      end
`endif
      // Pending command survives enable going low.
      S_HOLD: if (cmd_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rx_en     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_note  <= '0;
      cmd_len   <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= nxt;
      rx_en     <= enable && (nxt != S_HOLD);
      cmd_valid <= (nxt == S_HOLD);
      err       <= err_set;
      if (ld_note) cmd_note <= rx_data;
      if (ld_len)  cmd_len  <= rx_data;
      if (err_set) err_code <= err_nxt;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl. Follows the build
// option UART_CMD_CHECKSUM_EN to decide whether frames carry a checksum.
module tb_uart_cmd_ctrl;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rx_stop;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_note;
  logic [7:0] cmd_len;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  uart_cmd_ctrl #(.HDR(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rx_stop   (rx_stop),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_note  (cmd_note),
    .cmd_len   (cmd_len),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte for exactly one posedge; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_stop = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_stop = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] n, input logic [7:0] l, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(n);
    send_byte(l);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(c);
`endif
  endtask

  task automatic expect_reset_vals(input string tag);
    chk({tag, ".rx_en"},     32'(rx_en),     32'd0);
    chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, ".note"},      32'(cmd_note),  32'd0);
    chk({tag, ".len"},       32'(cmd_len),   32'd0);
    chk({tag, ".err"},       32'(err),       32'd0);
    chk({tag, ".err_code"},  32'(err_code),  32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; rx_stop = 1'b0; rx_data = 8'h00; cmd_ready = 1'b1;
    #12;
    expect_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rx_en_after_rst", 32'(rx_en), 32'd1);

    // T1: good frame, player ready -> single cmd_valid cycle
    send_frame(8'h3C, 8'h10, 8'hF1);
    chk("t1.valid", 32'(cmd_valid), 32'd1);
    chk("t1.note",  32'(cmd_note),  32'h3C);
    chk("t1.len",   32'(cmd_len),   32'h10);
    chk("t1.rx_en", 32'(rx_en),     32'd0);
    chk("t1.err",   32'(err),       32'd0);
    @(negedge clk);
    chk("t1.valid_drop", 32'(cmd_valid), 32'd0);
    chk("t1.rx_en_back", 32'(rx_en),     32'd1);
    chk("t1.busy",       32'(busy),      32'd0);

    // T2: player stalls 20 cycles
    cmd_ready = 1'b0;
    send_frame(8'h3C, 8'h10, 8'hF1);
    for (int i = 0; i < 20; i++) begin
      chk("t2.valid", 32'(cmd_valid), 32'd1);
      chk("t2.rx_en", 32'(rx_en),     32'd0);
      chk("t2.note",  32'(cmd_note),  32'h3C);
      chk("t2.len",   32'(cmd_len),   32'h10);
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("t2.valid_drop", 32'(cmd_valid), 32'd0);
    chk("t2.rx_en_back", 32'(rx_en),     32'd1);

`ifdef UART_CMD_CHECKSUM_EN
    // T3: bad checksum
    send_frame(8'h3C, 8'h10, 8'h00);
    chk("t3.err",      32'(err),       32'd1);
    chk("t3.err_code", 32'(err_code),  32'd2);
    chk("t3.valid",    32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("t3.err_width", 32'(err),      32'd0);
    chk("t3.code_held", 32'(err_code), 32'd2);
`endif

    // T4: timeout after A5,3C
    send_byte(8'hA5);
    send_byte(8'h3C);
    repeat (TO - 1) @(negedge clk);
    chk("t4.err_early", 32'(err),  32'd0);
    chk("t4.busy_pre",  32'(busy), 32'd1);
    @(negedge clk);
    chk("t4.err",      32'(err),       32'd1);
    chk("t4.err_code", 32'(err_code),  32'd1);
    chk("t4.busy",     32'(busy),      32'd0);
    chk("t4.valid",    32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("t4.err_width", 32'(err), 32'd0);

    // T5: leading junk ignored
    send_byte(8'h11);
    send_byte(8'h22);
    chk("t5.junk_busy", 32'(busy), 32'd0);
    chk("t5.junk_err",  32'(err),  32'd0);
    send_frame(8'h05, 8'h06, 8'hB0);
    chk("t5.valid", 32'(cmd_valid), 32'd1);
    chk("t5.note",  32'(cmd_note),  32'h05);
    chk("t5.len",   32'(cmd_len),   32'h06);
    @(negedge clk);

    // T6: byte on the expiry cycle wins over the timeout
    send_byte(8'hA5);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h07);
    chk("t6.no_err", 32'(err),  32'd0);
    chk("t6.busy",   32'(busy), 32'd1);
    send_byte(8'h08);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hB4);
`endif
    chk("t6.valid", 32'(cmd_valid), 32'd1);
    chk("t6.note",  32'(cmd_note),  32'h07);
    chk("t6.len",   32'(cmd_len),   32'h08);
    @(negedge clk);

    // T7: enable low mid-frame aborts silently
    send_byte(8'hA5);
    enable = 1'b0;
    @(negedge clk);
    chk("t7.busy",  32'(busy),  32'd0);
    chk("t7.err",   32'(err),   32'd0);
    chk("t7.rx_en", 32'(rx_en), 32'd0);
    enable = 1'b1;
    @(negedge clk);

    // T8: async reset mid-frame, then a clean frame
    send_byte(8'hA5);
    send_byte(8'h3C);
    #2 rst = 1'b0;
    #1;
    expect_reset_vals("t8.rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t8.rx_en", 32'(rx_en), 32'd1);
    send_frame(8'h3C, 8'h10, 8'hF1);
    chk("t8.valid", 32'(cmd_valid), 32'd1);
    chk("t8.note",  32'(cmd_note),  32'h3C);
    chk("t8.len",   32'(cmd_len),   32'h10);
    @(negedge clk);
    chk("t8.valid_drop", 32'(cmd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
